// File: rtl/level_crossing_pkg.sv
// Shared definitions for the level-crossing wheel front-end: FSM states,
// filtered sensor patterns {A,B} and default timing parameters.
package level_crossing_pkg;

    // Sequence FSM states. The A-chain follows a wheel entering on sensor A,
    // the B-chain is its mirror for a wheel entering on sensor B.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_A1     = 3'd1,   // pattern 10
        ST_A2     = 3'd2,   // pattern 11
        ST_A3     = 3'd3,   // pattern 01
        ST_B1     = 3'd4,   // pattern 01
        ST_B2     = 3'd5,   // pattern 11
        ST_B3     = 3'd6,   // pattern 10
        ST_RESYNC = 3'd7
    } state_t;

    // Filtered sensor pattern P = {fA, fB}
    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_A    = 2'b10;
    localparam logic [1:0] P_B    = 2'b01;
    localparam logic [1:0] P_BOTH = 2'b11;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 50000;
    localparam int DEF_TO_W            = 16;

    // True while a wheel is being tracked through either chain; these are
    // the states in which the timeout counter runs.
    function automatic logic is_chain(input state_t s);
        return (s == ST_A1) || (s == ST_A2) || (s == ST_A3) ||
               (s == ST_B1) || (s == ST_B2) || (s == ST_B3);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser for the asynchronous raw input,
// followed by a counter-based debouncer. The filtered level only follows the
// synchronised level after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce
    import level_crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
    input  logic Clk,
    input  logic Reset,
    input  logic sens,
    output logic filt
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the accepting sample
    // updates the filtered level instead of incrementing.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise the raw sensor into the Clk domain.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sens;
            sync_p1 <= sync_p0;
        end
    end

    // Accept a new level only after it has been stable long enough; any return
    // to the current filtered level restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_p1 == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_q <= sync_p1;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/wheel_direction_decoder.sv
// Wheel direction decoder: debounces both track sensors and follows the
// overlapping-sensor pattern of a passing wheel. A single-cycle a2b or b2a
// pulse is produced only when a wheel fully clears both sensors in a
// consistent direction; illegal jumps and stalls produce a Fault pulse and
// park the FSM in RESYNC until the track is clear again.
module wheel_direction_decoder
    import level_crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TO_W            = DEF_TO_W
)(
    input  logic Clk,
    input  logic Reset,
    input  logic SensA,
    input  logic SensB,
    output logic a2b,
    output logic b2a,
    output logic Fault,
    output logic Busy
);

    // Last count value before the timeout is declared.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            filt_a;
    logic            filt_b;
    logic [1:0]      pat;

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;

    logic            a2b_d;
    logic            b2a_d;
    logic            fault_d;
    logic            step_exits;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .Clk   (Clk),
        .Reset (Reset),
        .sens  (SensA),
        .filt  (filt_a)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .Clk   (Clk),
        .Reset (Reset),
        .sens  (SensB),
        .filt  (filt_b)
    );

    assign pat = {filt_a, filt_b};

    // Next-state and pulse decode. Each chain state only accepts its own
    // pattern (hold) or a pattern one bit away along the chain; anything
    // else, including both bits flipping together, is a fault.
    always_comb begin
        state_d = state_q;
        a2b_d   = 1'b0;
        b2a_d   = 1'b0;
        fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                case (pat)
                    P_A:     state_d = ST_A1;
                    P_B:     state_d = ST_B1;
                    P_BOTH: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            ST_A1: begin
                case (pat)
                    P_A:     state_d = ST_A1;
                    P_BOTH:  state_d = ST_A2;
                    P_NONE:  state_d = ST_IDLE;   // wheel backed off sensor A
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_A2: begin
                case (pat)
                    P_BOTH:  state_d = ST_A2;
                    P_A:     state_d = ST_A1;
                    P_B:     state_d = ST_A3;
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_A3: begin
                case (pat)
                    P_B:     state_d = ST_A3;
                    P_BOTH:  state_d = ST_A2;
                    P_NONE: begin
                        state_d = ST_IDLE;
                        a2b_d   = 1'b1;
                    end
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_B1: begin
                case (pat)
                    P_B:     state_d = ST_B1;
                    P_BOTH:  state_d = ST_B2;
                    P_NONE:  state_d = ST_IDLE;   // wheel backed off sensor B
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_B2: begin
                case (pat)
                    P_BOTH:  state_d = ST_B2;
                    P_B:     state_d = ST_B1;
                    P_A:     state_d = ST_B3;
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_B3: begin
                case (pat)
                    P_A:     state_d = ST_B3;
                    P_BOTH:  state_d = ST_B2;
                    P_NONE: begin
                        state_d = ST_IDLE;
                        b2a_d   = 1'b1;
                    end
                    default: begin
                        state_d = ST_RESYNC;
                        fault_d = 1'b1;
                    end
                endcase
            end

            ST_RESYNC: begin
                if (pat == P_NONE) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_RESYNC;
                fault_d = 1'b1;
            end
        endcase

        // A pattern-driven exit (completion, back-off or fault) wins over the
        // timeout so that only one pulse can ever be produced per cycle.
        step_exits = (state_d == ST_IDLE) || (state_d == ST_RESYNC);
        if (is_chain(state_q) && (to_cnt_q == TO_LAST) && !step_exits) begin
            state_d = ST_RESYNC;
            fault_d = 1'b1;
        end

        to_cnt_d = is_chain(state_q) ? (to_cnt_q + TO_W'(1)) : '0;
    end

    // State and timeout registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Registered single-cycle event and fault pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a2b   <= 1'b0;
            b2a   <= 1'b0;
            Fault <= 1'b0;
        end else begin
            a2b   <= a2b_d;
            b2a   <= b2a_d;
            Fault <= fault_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);

endmodule
